// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture controller: FSM encoding, default frame
// geometry and small helpers for the ramp pattern the converter streams.
package adc_pkg;

  localparam int DEF_CHANNELS  = 32;
  localparam int DEF_DATAWIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_CALIB,
    S_RUN,
    S_DONE
  } state_t;

  function automatic int ramp_step(input int channels, input int datawidth);
    return channels % (1 << datawidth);
  endfunction

  // Frame-to-frame base increment of the ramp for the default geometry
  localparam int RAMP_STEP = ramp_step(DEF_CHANNELS, DEF_DATAWIDTH);

  function automatic logic [DEF_DATAWIDTH-1:0] lane_get(
    input logic [DEF_CHANNELS*DEF_DATAWIDTH-1:0] frame,
    input int                                    idx
  );
    return frame[idx*DEF_DATAWIDTH +: DEF_DATAWIDTH];
  endfunction

endpackage

// File: rtl/adc_frame_checker.sv
// Ramp-pattern integrity checker: flags a captured frame whose lanes are not a
// contiguous ramp or whose base does not follow the previous frame's base.
module adc_frame_checker
  import adc_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  logic [CHANNELS*DATAWIDTH-1:0] i_frame,
  output logic                          o_frame_bad
);

  localparam logic [DATAWIDTH-1:0] STEP = DATAWIDTH'(ramp_step(CHANNELS, DATAWIDTH));

  logic [DATAWIDTH-1:0] r_prev_base;
  logic                 r_seeded;
  logic [DATAWIDTH-1:0] w_base;
  logic                 w_lanes_ok;
  logic                 w_base_ok;

  assign w_base = i_frame[DATAWIDTH-1:0];

  always_comb begin
    w_lanes_ok = 1'b1;
    for (int i = 1; i < CHANNELS; i++) begin
      if (i_frame[i*DATAWIDTH +: DATAWIDTH] != w_base + DATAWIDTH'(i)) begin
        w_lanes_ok = 1'b0;
      end
    end
  end

  // The first frame after a clear only seeds the expected base
  assign w_base_ok   = !r_seeded || (w_base == r_prev_base + STEP);
  assign o_frame_bad = i_valid && !(w_lanes_ok && w_base_ok);

  // Always re-seed from the received frame so one bad frame costs one count
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_prev_base <= '0;
      r_seeded    <= 1'b0;
    end else if (i_valid) begin
      r_prev_base <= w_base;
      r_seeded    <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Sequences the ADC through ready/calibration/run, writes each strobed frame into
// the frame SRAM and counts frames that break the converter's ramp pattern.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int DEPTH     = 64,
  parameter int ADDRW     = 6,
  parameter int TIMEOUT   = 20000
) (
  input  logic                          i_clk_28G,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_adc_ready,
  output logic                          o_calib_start,
  input  logic                          i_adc_calib_done,
  output logic                          o_adc_run,
  input  logic [DATAWIDTH*CHANNELS-1:0] i_adc_data,
  input  logic                          i_en_sram,
  output logic                          o_mem_we,
  output logic [ADDRW-1:0]              o_mem_addr,
  output logic [DATAWIDTH*CHANNELS-1:0] o_mem_wdata,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout_err,
  output logic [15:0]                   o_err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [TW-1:0]                 r_timer;
  logic [ADDRW-1:0]              r_wr_addr;
  logic                          r_calib_start;
  logic                          r_adc_run;
  logic                          r_mem_we;
  logic [ADDRW-1:0]              r_mem_addr;
  logic [DATAWIDTH*CHANNELS-1:0] r_mem_wdata;
  logic                          r_timeout_err;
  logic [15:0]                   r_err_cnt;

  logic w_capture;
  logic w_last;
  logic w_clear;
  logic w_expired;
  logic w_timeout_hit;
  logic w_frame_bad;

  assign w_capture = (r_state == S_RUN) && i_en_sram;
  assign w_last    = (r_wr_addr == ADDRW'(DEPTH - 1));
  assign w_clear   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_expired = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE:     if (i_start) w_state_next = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (i_adc_ready) begin
          w_state_next = S_CALIB;
        end else if (w_expired) begin
          w_state_next  = S_DONE;
          w_timeout_hit = 1'b1;
        end
      end
      S_CALIB: begin
        if (i_adc_calib_done) begin
          w_state_next = S_RUN;
        end else if (w_expired) begin
          w_state_next  = S_DONE;
          w_timeout_hit = 1'b1;
        end
      end
      S_RUN:      if (w_capture && w_last) w_state_next = S_DONE;
      S_DONE:     if (i_start) w_state_next = S_WAIT_RDY;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Wait-state timer restarts on every state entry and only runs where a timeout applies
  always_ff @(posedge i_clk_28G) begin
    if (i_rst || (w_state_next != r_state)) begin
      r_timer <= '0;
    end else if ((r_state == S_WAIT_RDY) || (r_state == S_CALIB)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge i_clk_28G) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_calib_start <= 1'b0;
      r_adc_run     <= 1'b1;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_wr_addr     <= '0;
      r_timeout_err <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_calib_start <= (w_state_next == S_CALIB);
      r_adc_run     <= (w_state_next != S_RUN);
      r_mem_we      <= w_capture;
      if (w_capture) begin
        r_mem_addr  <= r_wr_addr;
        r_mem_wdata <= i_adc_data;
        r_wr_addr   <= r_wr_addr + 1'b1;
        if (w_frame_bad && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
      if (w_clear) begin
        r_wr_addr     <= '0;
        r_err_cnt     <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  adc_frame_checker #(
    .CHANNELS  (CHANNELS),
    .DATAWIDTH (DATAWIDTH)
  ) u_checker (
    .i_clk       (i_clk_28G),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_valid     (w_capture),
    .i_frame     (i_adc_data),
    .o_frame_bad (w_frame_bad)
  );

  assign o_calib_start = r_calib_start;
  assign o_adc_run     = r_adc_run;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_timeout_err = r_timeout_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl: drives ramp frames through a
// full capture sequence and compares outputs against hand-computed values.
module tb_adc_capture_ctrl;

  localparam int CH = 32;
  localparam int DW = 8;
  localparam int FW = CH * DW;

  logic          clk;
  logic          i_rst;
  logic          i_start;
  logic          i_adc_ready;
  logic          o_calib_start;
  logic          i_adc_calib_done;
  logic          o_adc_run;
  logic [FW-1:0] i_adc_data;
  logic          i_en_sram;
  logic          o_mem_we;
  logic [5:0]    o_mem_addr;
  logic [FW-1:0] o_mem_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout_err;
  logic [15:0]   o_err_cnt;

  int checks = 0;
  int errors = 0;
  int calibHigh = 0;
  logic [5:0]    wrAddr[$];
  logic [FW-1:0] wrData[$];

  adc_capture_ctrl #(
    .CHANNELS (CH),
    .DATAWIDTH(DW),
    .DEPTH    (64),
    .ADDRW    (6),
    .TIMEOUT  (20000)
  ) dut (
    .i_clk_28G       (clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_adc_ready     (i_adc_ready),
    .o_calib_start   (o_calib_start),
    .i_adc_calib_done(i_adc_calib_done),
    .o_adc_run       (o_adc_run),
    .i_adc_data      (i_adc_data),
    .i_en_sram       (i_en_sram),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_timeout_err   (o_timeout_err),
    .o_err_cnt       (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every SRAM write and every cycle with a calibration request
  always @(negedge clk) begin
    if (o_mem_we) begin
      wrAddr.push_back(o_mem_addr);
      wrData.push_back(o_mem_wdata);
    end
    if (o_calib_start) calibHigh++;
  end

  function automatic logic [FW-1:0] rampFrame(input logic [7:0] base);
    logic [FW-1:0] f;
    for (int i = 0; i < CH; i++) f[i*DW +: DW] = base + 8'(i);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n frames with bases base0, base0+32, ...; frame badIdx gets lane 5 forced to 0
  task automatic applyStimulus(input int n, input logic [7:0] base0, input int gap, input int badIdx);
    logic [7:0] b;
    b = base0;
    for (int k = 0; k < n; k++) begin
      i_adc_data = rampFrame(b);
      if (k == badIdx) i_adc_data[5*DW +: DW] = 8'h00;
      i_en_sram = 1'b1;
      tick();
      if (gap > 0) begin
        i_en_sram = 1'b0;
        repeat (gap) tick();
      end
      b = b + 8'd32;
    end
    i_en_sram = 1'b0;
  endtask

  task automatic startSeq(input int readyDelay);
    i_adc_ready = 1'b0;
    i_adc_calib_done = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_calib_start !== 1'b0) begin errors++; $display("[TB] FAIL wait_rdy_entry: got busy=%b calib=%b expected busy=1 calib=0", o_busy, o_calib_start); end
    repeat (readyDelay) tick();
    if (readyDelay > 0) begin
      checks++; if (o_calib_start !== 1'b0) begin errors++; $display("[TB] FAIL calib_held_low: got %b expected 0", o_calib_start); end
    end
    i_adc_ready = 1'b1;
    tick();
    checks++; if (o_calib_start !== 1'b1 || o_adc_run !== 1'b1) begin errors++; $display("[TB] FAIL calib_rise: got calib=%b run=%b expected calib=1 run=1", o_calib_start, o_adc_run); end
    tick();
    checks++; if (o_calib_start !== 1'b1) begin errors++; $display("[TB] FAIL calib_hold: got %b expected 1", o_calib_start); end
    i_adc_calib_done = 1'b1;
    tick();
    i_adc_calib_done = 1'b0;
    checks++; if (o_adc_run !== 1'b0 || o_calib_start !== 1'b0) begin errors++; $display("[TB] FAIL run_fall: got run=%b calib=%b expected run=0 calib=0", o_adc_run, o_calib_start); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_adc_ready = 1'b0;
    i_adc_calib_done = 1'b0;
    i_en_sram = 1'b0;
    i_adc_data = '0;
    tick();
    tick();
    checks++; if ({o_calib_start, o_adc_run, o_mem_we, o_busy, o_done, o_timeout_err} !== 6'b010000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 010000", {o_calib_start, o_adc_run, o_mem_we, o_busy, o_done, o_timeout_err}); end
    checks++; if (o_mem_addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", o_mem_addr); end
    checks++; if (o_mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %0h expected 0", o_mem_wdata); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", o_err_cnt); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int badAddr;
    int badLane;
    wrAddr.delete();
    wrData.delete();
    startSeq(3);
    applyStimulus(64, 8'd32, 1, -1);
    tick();
    checks++; if (wrAddr.size() !== 64) begin errors++; $display("[TB] FAIL nominal_writes: got %0d expected 64", wrAddr.size()); end
    badAddr = 0;
    for (int i = 0; i < wrAddr.size(); i++) if (wrAddr[i] !== 6'(i)) badAddr++;
    checks++; if (badAddr !== 0) begin errors++; $display("[TB] FAIL nominal_addr_seq: got %0d wrong addresses expected 0", badAddr); end
    badLane = 0;
    if (wrData.size() >= 2) begin
      for (int i = 0; i < CH; i++) begin
        if (wrData[0][i*DW +: DW] !== 8'(32 + i)) badLane++;
        if (wrData[1][i*DW +: DW] !== 8'(64 + i)) badLane++;
      end
    end else badLane = 99;
    checks++; if (badLane !== 0) begin errors++; $display("[TB] FAIL nominal_frame_lanes: got %0d wrong lanes expected 0", badLane); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL nominal_err_cnt: got %0d expected 0", o_err_cnt); end
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("[TB] FAIL nominal_done: got done=%b busy=%b expected done=1 busy=0", o_done, o_busy); end
    checks++; if (o_adc_run !== 1'b1) begin errors++; $display("[TB] FAIL nominal_adc_run: got %b expected 1", o_adc_run); end
  endtask

  task automatic test_back_to_back();
    int expBase[9] = '{32, 64, 96, 128, 160, 192, 224, 0, 32};
    int badBase;
    wrAddr.delete();
    wrData.delete();
    startSeq(0);
    applyStimulus(9, 8'd32, 0, -1);
    checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 6'd8) begin errors++; $display("[TB] FAIL b2b_last_write: got we=%b addr=%0d expected we=1 addr=8", o_mem_we, o_mem_addr); end
    tick();
    checks++; if (wrAddr.size() !== 9) begin errors++; $display("[TB] FAIL b2b_writes: got %0d expected 9", wrAddr.size()); end
    badBase = 0;
    for (int i = 0; i < 9 && i < wrData.size(); i++) if (wrData[i][7:0] !== 8'(expBase[i])) badBase++;
    checks++; if (badBase !== 0) begin errors++; $display("[TB] FAIL wrap_bases: got %0d wrong bases expected 0", badBase); end
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL wrap_err_cnt: got %0d expected 0", o_err_cnt); end
  endtask

  task automatic test_ignored_start();
    int badAddr;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_done !== 1'b0 || o_adc_run !== 1'b0) begin errors++; $display("[TB] FAIL ignored_start_state: got busy=%b done=%b run=%b expected 1 0 0", o_busy, o_done, o_adc_run); end
    tick();
    applyStimulus(55, 8'd64, 1, -1);
    tick();
    checks++; if (wrAddr.size() !== 64) begin errors++; $display("[TB] FAIL ignored_start_writes: got %0d expected 64", wrAddr.size()); end
    badAddr = 0;
    for (int i = 0; i < wrAddr.size(); i++) if (wrAddr[i] !== 6'(i)) badAddr++;
    checks++; if (badAddr !== 0) begin errors++; $display("[TB] FAIL ignored_start_addr: got %0d wrong addresses expected 0", badAddr); end
    checks++; if (o_done !== 1'b1 || o_err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL ignored_start_done: got done=%b err=%0d expected done=1 err=0", o_done, o_err_cnt); end
  endtask

  task automatic test_corruption();
    wrAddr.delete();
    wrData.delete();
    startSeq(0);
    applyStimulus(3, 8'd32, 1, -1);
    checks++; if (o_err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL corrupt_pre: got %0d expected 0", o_err_cnt); end
    applyStimulus(1, 8'd128, 0, 0);
    checks++; if (o_mem_we !== 1'b1 || o_err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL corrupt_err_timing: got we=%b err=%0d expected we=1 err=1", o_mem_we, o_err_cnt); end
    tick();
    applyStimulus(60, 8'd160, 1, -1);
    tick();
    checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL corrupt_err_final: got %0d expected 1", o_err_cnt); end
    checks++; if (wrData.size() < 5 || wrData[4] !== rampFrame(8'd160)) begin errors++; $display("[TB] FAIL corrupt_frame4_written: got %0d writes expected frame 4 with base 160", wrData.size()); end
    checks++; if (wrAddr.size() !== 64 || o_done !== 1'b1) begin errors++; $display("[TB] FAIL corrupt_run_end: got writes=%0d done=%b expected 64 1", wrAddr.size(), o_done); end
  endtask

  task automatic test_timeout();
    int cyc;
    wrAddr.delete();
    wrData.delete();
    calibHigh = 0;
    i_adc_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_err_cnt !== 16'd0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_entry: got err=%0d busy=%b expected 0 1", o_err_cnt, o_busy); end
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 20100) begin
      tick();
      cyc++;
    end
    checks++; if (cyc < 20000 || cyc > 20001) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d expected 20000", cyc); end
    checks++; if (o_timeout_err !== 1'b1 || o_done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flags: got terr=%b done=%b expected 1 1", o_timeout_err, o_done); end
    checks++; if (calibHigh !== 0 || o_adc_run !== 1'b1) begin errors++; $display("[TB] FAIL timeout_no_calib: got calib_cycles=%0d run=%b expected 0 1", calibHigh, o_adc_run); end
    tick();
    checks++; if (wrAddr.size() !== 0) begin errors++; $display("[TB] FAIL timeout_no_writes: got %0d expected 0", wrAddr.size()); end
  endtask

  task automatic test_reset_mid_run();
    wrAddr.delete();
    wrData.delete();
    startSeq(0);
    checks++; if (o_timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_clears_timeout: got %b expected 0", o_timeout_err); end
    applyStimulus(10, 8'd32, 0, 2);
    checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL midrun_pre_err: got %0d expected 1", o_err_cnt); end
    i_adc_data = rampFrame(8'd96);
    i_en_sram = 1'b1;
    i_rst = 1'b1;
    tick();
    checks++; if (o_mem_we !== 1'b0 || o_adc_run !== 1'b1 || o_calib_start !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_ctrl: got we=%b run=%b calib=%b expected 0 1 0", o_mem_we, o_adc_run, o_calib_start); end
    checks++; if (o_err_cnt !== 16'd0 || o_mem_addr !== 6'd0) begin errors++; $display("[TB] FAIL midrun_reset_regs: got err=%0d addr=%0d expected 0 0", o_err_cnt, o_mem_addr); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_idle: got busy=%b done=%b expected 0 0", o_busy, o_done); end
    i_rst = 1'b0;
    i_en_sram = 1'b0;
    tick();
    checks++; if (wrAddr.size() !== 10) begin errors++; $display("[TB] FAIL midrun_partial_write: got %0d writes expected 10", wrAddr.size()); end
    wrAddr.delete();
    wrData.delete();
    startSeq(0);
    applyStimulus(2, 8'd32, 1, -1);
    tick();
    checks++; if (wrAddr.size() !== 2 || wrAddr[0] !== 6'd0 || wrAddr[1] !== 6'd1) begin errors++; $display("[TB] FAIL midrun_restart_addr: got %0d writes expected addr 0,1", wrAddr.size()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_ignored_start();
    test_corruption();
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Digital-side counterpart to the behavioural ADC: sequences the ADC through ready → calibration → run, captures each frame presented on the wide ADC data bus when `en_sram` pulses, and writes it into an on-chip frame SRAM. Every captured frame is also checked against the ADC's ramp pattern, so the block doubles as the bench-level data-integrity monitor for the converter link.

## Interface
- `CHANNELS`, 32, lanes per frame
- `DATAWIDTH`, 8, bits per lane
- `DEPTH`, 64, frames captured per run (power of two)
- `ADDRW`, 6, SRAM address width, equal to log2(DEPTH)
- `TIMEOUT`, 20000, max cycles spent in any wait state

- `clk_28G`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a sequence from IDLE
- `adc_ready`  in  1  ADC ready/not-busy
- `calib_start`  out  1  calibration request
- `adc_calib_done`  in  1  calibration complete
- `adc_run`  out  1  held high until conversion is wanted; ADC streams after it falls
- `adc_data`  in  DATAWIDTH*CHANNELS  frame, lane i at bits [i*DATAWIDTH +: DATAWIDTH]
- `en_sram`  in  1  one-cycle frame-valid strobe
- `mem_we`  out  1  SRAM write enable
- `mem_addr`  out  ADDRW  SRAM write address
- `mem_wdata`  out  DATAWIDTH*CHANNELS  SRAM write data
- `busy`  out  1  high in any state except IDLE/DONE
- `done`  out  1  high in DONE
- `timeout_err`  out  1  sticky wait-state timeout
- `err_cnt`  out  16  saturating count of bad frames

## Operation
- Reset values: `calib_start`=0, `adc_run`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `timeout_err`=0, `err_cnt`=0; FSM → IDLE.
- FSM states: IDLE, WAIT_RDY, CALIB, RUN, DONE.
- IDLE: `start` → WAIT_RDY; clears `err_cnt`, `timeout_err`, write address, checker state.
- WAIT_RDY: `adc_ready`=1 → CALIB, asserting `calib_start`.
- CALIB: hold `calib_start`=1 until `adc_calib_done`=1; then drop `calib_start`, drive `adc_run`=0 → RUN.
- RUN: on each cycle with `en_sram`=1, capture `adc_data`; write to `mem_addr`, which increments and wraps at DEPTH. After the DEPTH-th write, go to DONE and raise `adc_run`=1.
- DONE: hold until `start` (→ WAIT_RDY, same clears as IDLE). `start` is ignored in every other state.
- Timeout: a cycle counter resets on every state entry. If it reaches TIMEOUT in WAIT_RDY or CALIB, set `timeout_err`, force `calib_start`=0 and `adc_run`=1, and go to DONE. RUN has no timeout.
- Ramp check, per captured frame:
  - Lane i must equal (base + i) mod 2^DATAWIDTH, where base is lane 0 of that frame.
  - For every frame after the first, base must equal (previous base + CHANNELS) mod 2^DATAWIDTH.
  - The first frame of a run only seeds the expected base.
  - Any violation adds 1 to `err_cnt` (saturating at 0xFFFF). The expected base then re-seeds from the received frame, so one bad frame costs one count.
- Synchronous `rst` in any state, including mid-write, returns all outputs to their reset values on the next edge. A partial frame is never written.

## Timing
- `en_sram` sampled high at edge N → `mem_we`=1, `mem_wdata`=frame, `mem_addr`=k at edge N+1, for exactly one cycle.
- `err_cnt` for a frame updates at edge N+1, together with its `mem_we`.
- State transitions take effect one edge after the qualifying input. `calib_start` rises the edge after `adc_ready` is sampled high.
- `adc_run` falls at the edge after `adc_calib_done` is sampled high.
- `done`/`busy` follow the registered state.
- Back-to-back `en_sram` (every cycle) is supported at full rate.

## Structure
- Shared package `adc_pkg`:
  - FSM state encoding
  - CHANNELS/DATAWIDTH defaults
  - lane-extract helper
  - ramp-step constant CHANNELS mod 2^DATAWIDTH
- Sub-module `adc_frame_checker`: registered frame in, `frame_bad` out, base/first-frame tracking, cleared by the parent's clear pulse.

## Test plan
- Nominal (CHANNELS=32, DEPTH=64):
  - Stimulus: `start`, ready, calib, run.
  - Required: 64 writes, addr 0..63; frame 0 lanes 32..63, frame 1 lanes 64..95; `err_cnt`=0; `done`=1; `adc_run`=1.
- Wrap:
  - Stimulus: 9 consecutive frames.
  - Required: base sequence 32,64,…,224,0,32, with no errors across the 224→0 wrap.
- Corruption:
  - Stimulus: lane 5 of frame 3 forced to 0x00.
  - Required: `err_cnt`=1; frame 4 is still accepted.
- Timeout:
  - Stimulus: `adc_ready` held 0.
  - Required: after 20000 cycles, `timeout_err`=1, `done`=1, no `calib_start`, and zero `mem_we` pulses.
- Reset mid-run:
  - Stimulus: `rst` asserted after 10 frames.
  - Required: next edge shows `mem_we`=0, `adc_run`=1, `err_cnt`=0, state IDLE; a new `start` restarts at addr 0.
- Ignored start:
  - Stimulus: `start` pulsed during RUN.
  - Required: no effect on address sequence or state.
